write_back_stage: RTL



---
 rtl/pipeline_pkg.sv | 19 +
 rtl/load_align.sv | 19 +
 rtl/write_back_stage.sv | 61 ++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared load-width encodings, register constants and the WB register layout.
package pipeline_pkg;
  localparam logic [1:0] WIDTH_WORD = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_BYTE = 2'b10;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memtoreg;
    logic [1:0] width;
    logic unsgn;
    logic [1:0] addr;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0] rdest;
    logic [5:0] opcode;
  } wb_reg_t;
endpackage

// File: rtl/load_align.sv
// load_align: little-endian sub-word extraction with sign/zero extension of load data.
module load_align
  import pipeline_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  addr,
  input  logic [1:0]  width,
  input  logic        unsgn,
  output logic [31:0] aligned
);
  logic [15:0] half;
  logic [7:0]  byte_v;
  always_comb begin
    half = addr[1] ? raw[31:16] : raw[15:0];
    byte_v = 8'(raw >> {addr, 3'b000});
    aligned = (width == WIDTH_HALF) ? {{16{~unsgn & half[15]}}, half} :
              (width == WIDTH_BYTE) ? {{24{~unsgn & byte_v[7]}}, byte_v} : raw;
  end
endmodule

// File: rtl/write_back_stage.sv
// write_back_stage: WB pipeline register, load alignment and register-file write port.
// Optional retired-instruction counter enabled by WB_RETIRE_COUNT_EN.
module write_back_stage
  import pipeline_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Valid_MEM,
  input  logic        RegWrite_MEM,
  input  logic        MemToReg_MEM,
  input  logic [1:0]  R_Width_MEM,
  input  logic        Unsigned_MEM,
  input  logic [1:0]  Addr_MEM,
  input  logic [31:0] ALUResult_MEM,
  input  logic [31:0] MemReadData_MEM,
  input  logic [4:0]  rDestSelected_MEM,
  input  logic [5:0]  Opcode_MEM,
  input  logic        Stall_WB,
  input  logic        Flush_WB,
  output logic [4:0]  rDestSelected_ID,
  output logic [31:0] regWriteData,
  output logic        RegWrite,
  output logic [5:0]  Opcode_WB,
  output logic [31:0] Retired_Count
);
  wb_reg_t wb_d, wb_q;
  logic [31:0] load_data;
  always_comb begin
    wb_d = Flush_WB ? '0 : Stall_WB ? wb_q :
           '{valid: Valid_MEM, regwrite: RegWrite_MEM, memtoreg: MemToReg_MEM,
             width: R_Width_MEM, unsgn: Unsigned_MEM, addr: Addr_MEM,
             alu: ALUResult_MEM, mem: MemReadData_MEM,
             rdest: rDestSelected_MEM, opcode: Opcode_MEM};
  end
  always_ff @(posedge Clock) begin
    if (Reset) wb_q <= '0;
    else wb_q <= wb_d;
  end
  load_align u_align (
    .raw(wb_q.mem),
    .addr(wb_q.addr),
    .width(wb_q.width),
    .unsgn(wb_q.unsgn),
    .aligned(load_data)
  );
  assign regWriteData = wb_q.memtoreg ? load_data : wb_q.alu;
  assign RegWrite = wb_q.valid & wb_q.regwrite & (wb_q.rdest != REG_ZERO);
  assign rDestSelected_ID = wb_q.rdest;
  assign Opcode_WB = wb_q.opcode;
`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] cnt_d, cnt_q;
  always_comb cnt_d = cnt_q + {31'b0, Valid_MEM & ~Flush_WB & ~Stall_WB};
  always_ff @(posedge Clock) begin
    if (Reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign Retired_Count = cnt_q;
`else
  assign Retired_Count = '0;
`endif
endmodule
